// File: rtl/regfile_port_arbiter_pkg.sv
// rtl/regfile_port_arbiter_pkg.sv - shared widths, x0 address and read-owner encoding
package regfile_port_arbiter_pkg;

    localparam int REG_COUNT  = 32;
    localparam int REG_ADDR_W = $clog2(REG_COUNT);
    localparam int REG_DATA_W = 8;

    localparam logic [REG_ADDR_W-1:0] X0_ADDR = '0;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
        return addr == X0_ADDR;
    endfunction

endpackage

// File: rtl/regfile_read_tracker.sv
// rtl/regfile_read_tracker.sv - tracks the 1-cycle read latency, read owner and write bypass
module regfile_read_tracker
    import regfile_port_arbiter_pkg::*;
(
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  owner_e                i_rd_owner,
    input  logic                  i_dbg_ack,
    input  logic [REG_ADDR_W-1:0] i_rd_addr1,
    input  logic [REG_ADDR_W-1:0] i_rd_addr2,
    input  logic                  i_wr_en,
    input  logic [REG_ADDR_W-1:0] i_wr_addr,
    input  logic [REG_DATA_W-1:0] i_wr_data,
    input  logic [REG_DATA_W-1:0] i_rf_read_data1,
    input  logic [REG_DATA_W-1:0] i_rf_read_data2,
    output logic                  o_core_rd_valid,
    output logic [REG_DATA_W-1:0] o_core_rd_data1,
    output logic [REG_DATA_W-1:0] o_core_rd_data2,
    output logic                  o_dbg_rvalid,
    output logic [REG_DATA_W-1:0] o_dbg_rdata
);

    owner_e                r_owner;
    logic                  r_dbg_ack;
    logic [REG_ADDR_W-1:0] r_rd_addr1;
    logic [REG_ADDR_W-1:0] r_rd_addr2;
    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic [REG_DATA_W-1:0] r_wr_data;

    logic [REG_DATA_W-1:0] w_data1;
    logic [REG_DATA_W-1:0] w_data2;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_owner    <= OWN_NONE;
            r_dbg_ack  <= 1'b0;
            r_rd_addr1 <= '0;
            r_rd_addr2 <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
        end else begin
            r_owner    <= i_rd_owner;
            r_dbg_ack  <= i_dbg_ack;
            r_rd_addr1 <= i_rd_addr1;
            r_rd_addr2 <= i_rd_addr2;
            r_wr_en    <= i_wr_en & ~is_x0(i_wr_addr);
            r_wr_addr  <= i_wr_addr;
            r_wr_data  <= i_wr_data;
        end
    end

    // The register file returns pre-write data on a same-cycle hit, so the
    // write captured alongside the read overrides it here.
    always_comb begin
        w_data1 = i_rf_read_data1;
        if (is_x0(r_rd_addr1)) begin
            w_data1 = '0;
        end else if (r_wr_en && (r_rd_addr1 == r_wr_addr)) begin
            w_data1 = r_wr_data;
        end

        w_data2 = i_rf_read_data2;
        if (is_x0(r_rd_addr2)) begin
            w_data2 = '0;
        end else if (r_wr_en && (r_rd_addr2 == r_wr_addr)) begin
            w_data2 = r_wr_data;
        end
    end

    assign o_core_rd_valid = (r_owner == OWN_CORE);
    assign o_core_rd_data1 = o_core_rd_valid ? w_data1 : '0;
    assign o_core_rd_data2 = o_core_rd_valid ? w_data2 : '0;
    assign o_dbg_rvalid    = r_dbg_ack;
    assign o_dbg_rdata     = (r_dbg_ack && (r_owner == OWN_DBG)) ? w_data1 : '0;

endmodule

// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - shares register file ports between the core and debug access
module regfile_port_arbiter
    import regfile_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 8
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_core_rd_req,
    input  logic [REG_ADDR_W-1:0] i_core_rd_addr1,
    input  logic [REG_ADDR_W-1:0] i_core_rd_addr2,
    input  logic                  i_core_wr_req,
    input  logic [REG_ADDR_W-1:0] i_core_wr_addr,
    input  logic [REG_DATA_W-1:0] i_core_wr_data,
    output logic                  o_core_stall,
    output logic                  o_core_rd_valid,
    output logic [REG_DATA_W-1:0] o_core_rd_data1,
    output logic [REG_DATA_W-1:0] o_core_rd_data2,
    input  logic                  i_dbg_req,
    input  logic                  i_dbg_we,
    input  logic [REG_ADDR_W-1:0] i_dbg_addr,
    input  logic [REG_DATA_W-1:0] i_dbg_wdata,
    output logic                  o_dbg_ready,
    output logic                  o_dbg_rvalid,
    output logic [REG_DATA_W-1:0] o_dbg_rdata,
    output logic [REG_ADDR_W-1:0] o_rf_read_reg1,
    output logic [REG_ADDR_W-1:0] o_rf_read_reg2,
    output logic [REG_ADDR_W-1:0] o_rf_write_reg,
    output logic [REG_DATA_W-1:0] o_rf_write_reg_data,
    output logic                  o_rf_reg_write,
    input  logic [REG_DATA_W-1:0] i_rf_read_data1,
    input  logic [REG_DATA_W-1:0] i_rf_read_data2
);

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0]      r_wait_cnt;

    logic                  w_core_active;
    logic                  w_dbg_grant;
    logic                  w_core_grant;
    logic [REG_ADDR_W-1:0] w_rd_addr1;
    logic [REG_ADDR_W-1:0] w_rd_addr2;
    logic                  w_wr_sel;
    logic [REG_ADDR_W-1:0] w_wr_addr;
    logic [REG_DATA_W-1:0] w_wr_data;
    logic                  w_wr_en;
    owner_e                w_rd_owner;

    // Reset masks both grants so nothing reaches the register file meanwhile.
    assign w_core_active = i_core_rd_req | i_core_wr_req;
    assign w_dbg_grant   = ~i_reset & i_dbg_req & (~w_core_active | (r_wait_cnt == WAIT_LIMIT));
    assign w_core_grant  = ~i_reset & w_core_active & ~w_dbg_grant;

    assign o_core_stall  = w_core_active & w_dbg_grant;
    assign o_dbg_ready   = w_dbg_grant;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wait_cnt <= '0;
        end else if (w_dbg_grant || !i_dbg_req) begin
            r_wait_cnt <= '0;
        end else if (r_wait_cnt != WAIT_LIMIT) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_rd_addr1 = '0;
        w_rd_addr2 = '0;
        w_wr_sel   = 1'b0;
        w_wr_addr  = '0;
        w_wr_data  = '0;
        w_rd_owner = OWN_NONE;
        if (w_dbg_grant) begin
            w_wr_addr = i_dbg_addr;
            w_wr_data = i_dbg_wdata;
            if (i_dbg_we) begin
                w_wr_sel = 1'b1;
            end else begin
                w_rd_addr1 = i_dbg_addr;
                w_rd_owner = OWN_DBG;
            end
        end else if (w_core_grant) begin
            w_wr_sel  = i_core_wr_req;
            w_wr_addr = i_core_wr_addr;
            w_wr_data = i_core_wr_data;
            if (i_core_rd_req) begin
                w_rd_addr1 = i_core_rd_addr1;
                w_rd_addr2 = i_core_rd_addr2;
                w_rd_owner = OWN_CORE;
            end
        end
    end

    // x0 is hardwired to zero, so a write aimed at it never reaches the file.
    assign w_wr_en = w_wr_sel & ~is_x0(w_wr_addr);

    assign o_rf_read_reg1      = w_rd_addr1;
    assign o_rf_read_reg2      = w_rd_addr2;
    assign o_rf_write_reg      = w_wr_addr;
    assign o_rf_write_reg_data = w_wr_data;
    assign o_rf_reg_write      = w_wr_en;

    regfile_read_tracker u_tracker (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .i_rd_owner      (w_rd_owner),
        .i_dbg_ack       (w_dbg_grant),
        .i_rd_addr1      (w_rd_addr1),
        .i_rd_addr2      (w_rd_addr2),
        .i_wr_en         (w_wr_en),
        .i_wr_addr       (w_wr_addr),
        .i_wr_data       (w_wr_data),
        .i_rf_read_data1 (i_rf_read_data1),
        .i_rf_read_data2 (i_rf_read_data2),
        .o_core_rd_valid (o_core_rd_valid),
        .o_core_rd_data1 (o_core_rd_data1),
        .o_core_rd_data2 (o_core_rd_data2),
        .o_dbg_rvalid    (o_dbg_rvalid),
        .o_dbg_rdata     (o_dbg_rdata)
    );

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb/tb_regfile_port_arbiter.sv - directed table-driven bench with a behavioural register file
module tb_regfile_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       core_rd_req, core_wr_req, dbg_req, dbg_we;
    logic [4:0] core_rd_addr1, core_rd_addr2, core_wr_addr, dbg_addr;
    logic [7:0] core_wr_data, dbg_wdata;
    logic       core_stall, core_rd_valid, dbg_ready, dbg_rvalid, rf_we;
    logic [7:0] core_rd_data1, core_rd_data2, dbg_rdata, rf_wd, rf_rd1, rf_rd2;
    logic [4:0] rf_rr1, rf_rr2, rf_wa;
    logic [7:0] mem [32];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter #(.MAX_WAIT(4), .CNT_W(8)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_core_rd_req(core_rd_req), .i_core_rd_addr1(core_rd_addr1), .i_core_rd_addr2(core_rd_addr2),
        .i_core_wr_req(core_wr_req), .i_core_wr_addr(core_wr_addr), .i_core_wr_data(core_wr_data),
        .o_core_stall(core_stall), .o_core_rd_valid(core_rd_valid),
        .o_core_rd_data1(core_rd_data1), .o_core_rd_data2(core_rd_data2),
        .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
        .o_dbg_ready(dbg_ready), .o_dbg_rvalid(dbg_rvalid), .o_dbg_rdata(dbg_rdata),
        .o_rf_read_reg1(rf_rr1), .o_rf_read_reg2(rf_rr2), .o_rf_write_reg(rf_wa),
        .o_rf_write_reg_data(rf_wd), .o_rf_reg_write(rf_we),
        .i_rf_read_data1(rf_rd1), .i_rf_read_data2(rf_rd2)
    );

    // Register file: registered reads returning pre-write data on a same-cycle hit.
    always @(posedge clk) begin
        rf_rd1 <= mem[rf_rr1];
        rf_rd2 <= mem[rf_rr2];
        if (rf_we) mem[rf_wa] <= rf_wd;
    end

    typedef struct {
        logic       rd_req; logic [4:0] ra1; logic [4:0] ra2;
        logic       wr_req; logic [4:0] wa;  logic [7:0] wd;
        logic       dreq;   logic dwe;       logic [4:0] da;  logic [7:0] dwd;
        logic       e_stall; logic e_ready;  logic chk_rd;
        logic [4:0] e_rr1;  logic [4:0] e_rr2;
        logic       e_we;   logic [4:0] e_wa; logic [7:0] e_wd;
        logic       e_crv;  logic [7:0] e_d1; logic [7:0] e_d2;
        logic       e_drv;  logic [7:0] e_dr;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        core_rd_req = 0; core_rd_addr1 = 0; core_rd_addr2 = 0;
        core_wr_req = 0; core_wr_addr = 0; core_wr_data = 0;
        dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    endtask

    task automatic drive(input vec_t v);
        core_rd_req = v.rd_req; core_rd_addr1 = v.ra1; core_rd_addr2 = v.ra2;
        core_wr_req = v.wr_req; core_wr_addr = v.wa; core_wr_data = v.wd;
        dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.da; dbg_wdata = v.dwd;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
        mem[0]  <= 8'hEE;
        mem[5]  <= 8'h3C;
        mem[9]  <= 8'h77;
        mem[12] <= 8'hC3;
        idle();

        vecs[0]  = '{0,0,0, 0,0,8'h00, 0,0,0,8'h00,    0,0,1, 0,0,  0,0,8'h00,    0,8'h00,8'h00, 0,8'h00};
        vecs[1]  = '{0,0,0, 0,0,8'h00, 1,0,5,8'h00,    0,1,1, 5,0,  0,0,8'h00,    0,8'h00,8'h00, 1,8'h3C};
        vecs[2]  = '{1,5,9, 0,0,8'h00, 0,0,0,8'h00,    0,0,1, 5,9,  0,0,8'h00,    1,8'h3C,8'h77, 0,8'h00};
        vecs[3]  = '{1,7,5, 1,7,8'hA5, 0,0,0,8'h00,    0,0,1, 7,5,  1,7,8'hA5,    1,8'hA5,8'h3C, 0,8'h00};
        vecs[4]  = '{0,0,0, 1,0,8'hFF, 0,0,0,8'h00,    0,0,1, 0,0,  0,0,8'h00,    0,8'h00,8'h00, 0,8'h00};
        vecs[5]  = '{1,0,7, 0,0,8'h00, 0,0,0,8'h00,    0,0,1, 0,7,  0,0,8'h00,    1,8'h00,8'hA5, 0,8'h00};
        vecs[6]  = '{0,0,0, 0,0,8'h00, 1,1,6,8'h99,    0,1,0, 0,0,  1,6,8'h99,    0,8'h00,8'h00, 1,8'h00};
        vecs[7]  = '{0,0,0, 0,0,8'h00, 1,0,6,8'h00,    0,1,1, 6,0,  0,0,8'h00,    0,8'h00,8'h00, 1,8'h99};
        vecs[8]  = '{1,9,12, 1,12,8'h5A, 1,0,5,8'h00,  0,0,1, 9,12, 1,12,8'h5A,   1,8'h77,8'h5A, 0,8'h00};
        vecs[9]  = '{0,0,0, 0,0,8'h00, 1,1,0,8'hFF,    0,1,0, 0,0,  0,0,8'h00,    0,8'h00,8'h00, 1,8'h00};
        vecs[10] = '{0,0,0, 0,0,8'h00, 1,0,0,8'h00,    0,1,1, 0,0,  0,0,8'h00,    0,8'h00,8'h00, 1,8'h00};
        vecs[11] = '{1,12,6, 0,0,8'h00, 0,0,0,8'h00,   0,0,1, 12,6, 0,0,8'h00,    1,8'h5A,8'h99, 0,8'h00};

        // Reset with requests pending: every output must stay quiet.
        #2 rst = 1'b1;
        core_rd_req = 1; core_rd_addr1 = 5; core_rd_addr2 = 9; dbg_req = 1; dbg_addr = 5;
        @(negedge clk); #1;
        check("rst_dbg_ready", dbg_ready, 0);
        check("rst_core_stall", core_stall, 0);
        check("rst_rd_reg1", rf_rr1, 0);
        check("rst_core_rd_valid", core_rd_valid, 0);
        check("rst_dbg_rvalid", dbg_rvalid, 0);
        @(negedge clk);
        idle();
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d_stall", i), core_stall, vecs[i].e_stall);
            check($sformatf("v%0d_ready", i), dbg_ready, vecs[i].e_ready);
            check($sformatf("v%0d_reg_write", i), rf_we, vecs[i].e_we);
            if (vecs[i].chk_rd) begin
                check($sformatf("v%0d_read_reg1", i), rf_rr1, vecs[i].e_rr1);
                check($sformatf("v%0d_read_reg2", i), rf_rr2, vecs[i].e_rr2);
            end
            if (vecs[i].e_we) begin
                check($sformatf("v%0d_write_reg", i), rf_wa, vecs[i].e_wa);
                check($sformatf("v%0d_write_data", i), rf_wd, vecs[i].e_wd);
            end
            @(negedge clk);
            idle();
            #1;
            check($sformatf("v%0d_core_rd_valid", i), core_rd_valid, vecs[i].e_crv);
            check($sformatf("v%0d_core_rd_data1", i), core_rd_data1, vecs[i].e_d1);
            check($sformatf("v%0d_core_rd_data2", i), core_rd_data2, vecs[i].e_d2);
            check($sformatf("v%0d_dbg_rvalid", i), dbg_rvalid, vecs[i].e_drv);
            check($sformatf("v%0d_dbg_rdata", i), dbg_rdata, vecs[i].e_dr);
        end

        // Starvation: core busy every cycle, debug held; grants land on cycles 5 and 10.
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            core_rd_req = 1; core_rd_addr1 = 5; core_rd_addr2 = 9;
            dbg_req = 1; dbg_we = 0; dbg_addr = 9;
            #1;
            check($sformatf("starve_c%0d_ready", c), dbg_ready, (c == 5 || c == 10));
            check($sformatf("starve_c%0d_stall", c), core_stall, (c == 5 || c == 10));
            check($sformatf("starve_c%0d_core_rd_valid", c), core_rd_valid, (c > 1 && c != 6));
            check($sformatf("starve_c%0d_dbg_rvalid", c), dbg_rvalid, (c == 6));
            if (c > 1 && c != 6) check($sformatf("starve_c%0d_data1", c), core_rd_data1, 8'h3C);
            if (c == 6) check("starve_dbg_rdata", dbg_rdata, 8'h77);
        end
        @(negedge clk);
        idle();
        #1;
        check("starve_end_core_rd_valid", core_rd_valid, 0);
        check("starve_end_dbg_rvalid", dbg_rvalid, 1);
        check("starve_end_dbg_rdata", dbg_rdata, 8'h77);

        // Back-to-back debug write then read of x3.
        @(negedge clk);
        dbg_req = 1; dbg_we = 1; dbg_addr = 3; dbg_wdata = 8'h11;
        #1;
        check("b2b_wr_ready", dbg_ready, 1);
        check("b2b_wr_reg_write", rf_we, 1);
        @(negedge clk);
        dbg_we = 0; dbg_wdata = 8'h00;
        #1;
        check("b2b_rd_ready", dbg_ready, 1);
        check("b2b_wr_rvalid", dbg_rvalid, 1);
        check("b2b_wr_rdata", dbg_rdata, 8'h00);
        @(negedge clk);
        idle();
        #1;
        check("b2b_rd_rvalid", dbg_rvalid, 1);
        check("b2b_rd_rdata", dbg_rdata, 8'h11);

        // Reset between a core read grant and its response.
        @(negedge clk);
        core_rd_req = 1; core_rd_addr1 = 5; core_rd_addr2 = 9;
        #1;
        check("midrst_grant_stall", core_stall, 0);
        check("midrst_grant_read_reg1", rf_rr1, 5);
        #2;
        rst = 1'b1;
        idle();
        dbg_req = 1; dbg_addr = 5;
        #1;
        check("midrst_dbg_ready", dbg_ready, 0);
        check("midrst_core_rd_valid", core_rd_valid, 0);
        check("midrst_core_rd_data1", core_rd_data1, 0);
        @(posedge clk); #1;
        check("midrst_after_edge_valid", core_rd_valid, 0);
        check("midrst_after_edge_dbg_rvalid", dbg_rvalid, 0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        check("midrst_release_valid", core_rd_valid, 0);
        check("midrst_release_data2", core_rd_data2, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
